// File: rtl/usb_pkg.sv
// Shared USB/ULPI definitions: arbiter state encoding, requester IDs and
// default arbiter timing parameters.
package usb_pkg;

    // Arbiter FSM states, 4-bit encoded like the protocol state machine.
    typedef enum logic [3:0] {
        ARB_IDLE      = 4'd0,
        ARB_TURN      = 4'd1,
        ARB_GRANT_PKT = 4'd2,
        ARB_GRANT_REG = 4'd3,
        ARB_COOLDOWN  = 4'd4
    } arb_state_t;

    // Identity of a TX path requester.
    typedef enum logic {
        REQ_PKT = 1'b0,
        REQ_REG = 1'b1
    } req_id_t;

    localparam int unsigned TURN_CYCLES_DEF = 1;
    localparam int unsigned TIMEOUT_DEF     = 1024;
    localparam int unsigned CNT_W_DEF       = 11;

endpackage

// File: rtl/ulpi_tx_arbiter_if.sv
// Requester-side handshake bundle of the ULPI TX arbiter.
// master = requester blocks, slave = arbiter.
interface ulpi_tx_arbiter_if;
    logic req_pkt;
    logic req_reg;
    logic done_pkt;
    logic done_reg;
    logic gnt_pkt;
    logic gnt_reg;
    logic abort;
    logic timeout_err;
    logic bus_busy;

    modport master (
        output req_pkt, req_reg, done_pkt, done_reg,
        input  gnt_pkt, gnt_reg, abort, timeout_err, bus_busy
    );

    modport slave (
        input  req_pkt, req_reg, done_pkt, done_reg,
        output gnt_pkt, gnt_reg, abort, timeout_err, bus_busy
    );
endinterface

// File: rtl/ulpi_tx_arbiter_edge_detector.sv
// edge_detector: one-clk pulse on a rising (or falling) edge of a sampled
// input, using a single history register.
module edge_detector #(
    parameter bit FALLING = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic sig,
    output logic pulse
);
    logic sig_q;

    // Remember the previous sample of the input.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) sig_q <= 1'b0;
        else        sig_q <= sig;
    end

    assign pulse = FALLING ? (~sig & sig_q) : (sig & ~sig_q);
endmodule

// File: rtl/ulpi_tx_arbiter.sv
// ulpi_tx_arbiter: arbitrates the ULPI TX path between the packet
// transmitter and the register-access engine. Grants only while dir is low
// and after the turnaround, aborts instantly when the PHY reclaims the bus.
// Optional grant timeout enabled by defining ULPI_ARB_TIMEOUT_EN.
module ulpi_tx_arbiter
    import usb_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = TURN_CYCLES_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               ulpi_clk,
    input  logic               dir,
    input  logic               nxt,
    ulpi_tx_arbiter_if.slave   arb
);
    // The counter serves both the turnaround and the timeout; it saturates.
    localparam int unsigned CNT_SAT = (TIMEOUT > TURN_CYCLES) ? TIMEOUT : TURN_CYCLES;

    arb_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    req_id_t          last_grant, last_next;
    logic             ulpi_clk_rising;
    logic             dir_falling;
    logic             do_abort;
    logic             do_timeout;
    logic             gnt_pkt_d, gnt_reg_d, abort_d, bus_busy_d;

    // nxt is part of the monitored bus but does not influence arbitration.
    logic unused_nxt;
    assign unused_nxt = nxt;

    edge_detector #(.FALLING(1'b0)) u_ulpi_clk_rise (
        .clk(clk), .n_rst(n_rst), .sig(ulpi_clk), .pulse(ulpi_clk_rising)
    );

    edge_detector #(.FALLING(1'b1)) u_dir_fall (
        .clk(clk), .n_rst(n_rst), .sig(dir), .pulse(dir_falling)
    );

    // State, counter, round-robin memory and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ARB_TURN;
            cnt          <= '0;
            last_grant   <= REQ_REG;
            arb.gnt_pkt  <= 1'b0;
            arb.gnt_reg  <= 1'b0;
            arb.abort    <= 1'b0;
            arb.bus_busy <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            last_grant   <= last_next;
            arb.gnt_pkt  <= gnt_pkt_d;
            arb.gnt_reg  <= gnt_reg_d;
            arb.abort    <= abort_d;
            arb.bus_busy <= bus_busy_d;
        end
    end

`ifdef ULPI_ARB_TIMEOUT_EN
    // Registered timeout pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) arb.timeout_err <= 1'b0;
        else        arb.timeout_err <= do_timeout;
    end
`else
    assign arb.timeout_err = 1'b0;
`endif

    // Next-state, counter and round-robin decision.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        last_next  = last_grant;
        do_abort   = 1'b0;
        do_timeout = 1'b0;
        case (state)
            ARB_TURN: begin
                if (dir) begin
                    cnt_next = '0;
                end else if (cnt >= CNT_W'(TURN_CYCLES)) begin
                    state_next = ARB_IDLE;
                end else begin
                    // Turnaround restarts from zero at the dir falling edge.
                    cnt_next = dir_falling ? '0 : cnt;
                    if (ulpi_clk_rising && cnt_next < CNT_W'(CNT_SAT))
                        cnt_next = cnt_next + 1'b1;
                end
            end
            ARB_IDLE: begin
                if (dir) begin
                    state_next = ARB_TURN;
                    cnt_next   = '0;
                end else if (ulpi_clk_rising && (arb.req_pkt || arb.req_reg)) begin
                    cnt_next = '0;
                    if (arb.req_pkt && (!arb.req_reg || last_grant == REQ_REG)) begin
                        state_next = ARB_GRANT_PKT;
                        last_next  = REQ_PKT;
                    end else begin
                        state_next = ARB_GRANT_REG;
                        last_next  = REQ_REG;
                    end
                end
            end
            ARB_GRANT_PKT, ARB_GRANT_REG: begin
                if (dir) begin
                    do_abort   = 1'b1;
                    state_next = ARB_TURN;
                    cnt_next   = '0;
                end else if ((state == ARB_GRANT_PKT && arb.done_pkt) ||
                             (state == ARB_GRANT_REG && arb.done_reg)) begin
                    state_next = ARB_COOLDOWN;
                end
`ifdef ULPI_ARB_TIMEOUT_EN
                else if (cnt >= CNT_W'(TIMEOUT)) begin
                    do_timeout = 1'b1;
                    state_next = ARB_COOLDOWN;
                end else if (ulpi_clk_rising && cnt < CNT_W'(CNT_SAT)) begin
                    cnt_next = cnt + 1'b1;
                end
`endif
            end
            ARB_COOLDOWN: begin
                if (dir) begin
                    state_next = ARB_TURN;
                    cnt_next   = '0;
                end else if (ulpi_clk_rising) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_TURN;
                cnt_next   = '0;
            end
        endcase
    end

    // Output values, registered in the state process.
    always_comb begin
        gnt_pkt_d  = (state_next == ARB_GRANT_PKT);
        gnt_reg_d  = (state_next == ARB_GRANT_REG);
        abort_d    = do_abort;
        bus_busy_d = arb.gnt_pkt | arb.gnt_reg | dir;
    end
endmodule

// File: tb/tb_ulpi_tx_arbiter.sv
// Directed self-checking bench for ulpi_tx_arbiter (TURN_CYCLES = 1,
// TIMEOUT = 8). Covers ULPI_ARB_TIMEOUT_EN both defined and undefined.
module tb_ulpi_tx_arbiter;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic ulpi_clk = 1'b0;
    logic dir = 1'b0;
    logic nxt = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   to_seen = 0;

    ulpi_tx_arbiter_if arb ();

    ulpi_tx_arbiter #(.TURN_CYCLES(1), .TIMEOUT(8), .CNT_W(11)) dut (
        .clk(clk), .n_rst(n_rst), .ulpi_clk(ulpi_clk),
        .dir(dir), .nxt(nxt), .arb(arb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (arb.timeout_err === 1'b1) to_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full ulpi_clk period: high for one clk, low for one clk.
    task automatic uclk();
        ulpi_clk = 1'b1;
        @(negedge clk);
        ulpi_clk = 1'b0;
        @(negedge clk);
    endtask

    // Rising ulpi_clk edge; returns one clk later when a grant would appear.
    task automatic urise();
        ulpi_clk = 1'b1;
        @(negedge clk);
        ulpi_clk = 1'b0;
    endtask

    initial begin
        arb.req_pkt = 1'b1; arb.req_reg = 1'b1;
        arb.done_pkt = 1'b0; arb.done_reg = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt_pkt", 32'(arb.gnt_pkt), 0);
        check("rst_gnt_reg", 32'(arb.gnt_reg), 0);
        check("rst_abort", 32'(arb.abort), 0);
        check("rst_timeout", 32'(arb.timeout_err), 0);
        check("rst_busy", 32'(arb.bus_busy), 0);
        n_rst = 1'b1;

        // Turnaround edge, then first tie goes to pkt.
        uclk();
        check("turn_no_gnt", 32'({arb.gnt_pkt, arb.gnt_reg}), 0);
        urise();
        check("first_gnt_pkt", 32'(arb.gnt_pkt), 1);
        check("first_gnt_reg", 32'(arb.gnt_reg), 0);
        @(negedge clk);
        check("busy_grant", 32'(arb.bus_busy), 1);

        // Req drop and foreign done are ignored while granted.
        arb.req_pkt = 1'b0; arb.done_reg = 1'b1;
        @(negedge clk);
        arb.done_reg = 1'b0;
        check("ignore_done_reg", 32'(arb.gnt_pkt), 1);
        arb.req_pkt = 1'b1;

        // Alternation pkt -> reg -> pkt through COOLDOWN.
        arb.done_pkt = 1'b1;
        @(negedge clk);
        arb.done_pkt = 1'b0;
        check("done_pkt_drop", 32'(arb.gnt_pkt), 0);
        uclk();
        urise();
        check("alt_reg", 32'({arb.gnt_pkt, arb.gnt_reg}), 1);
        arb.done_reg = 1'b1;
        @(negedge clk);
        arb.done_reg = 1'b0;
        check("done_reg_drop", 32'(arb.gnt_reg), 0);
        uclk();
        urise();
        check("alt_pkt", 32'({arb.gnt_pkt, arb.gnt_reg}), 2);

        // dir rises during a reg grant.
        arb.done_pkt = 1'b1;
        @(negedge clk);
        arb.done_pkt = 1'b0;
        uclk();
        urise();
        check("pre_abort_reg", 32'(arb.gnt_reg), 1);
        dir = 1'b1;
        @(negedge clk);
        check("abort_pulse", 32'(arb.abort), 1);
        check("abort_gnt_drop", 32'(arb.gnt_reg), 0);
        @(negedge clk);
        check("abort_one_clk", 32'(arb.abort), 0);
        uclk();
        check("dir_hi_no_gnt", 32'({arb.gnt_pkt, arb.gnt_reg}), 0);
        check("dir_hi_busy", 32'(arb.bus_busy), 1);
        dir = 1'b0;
        uclk();
        check("turn_edge_no_gnt", 32'({arb.gnt_pkt, arb.gnt_reg}), 0);
        check("idle_not_busy", 32'(arb.bus_busy), 0);
        urise();
        check("post_turn_pkt", 32'({arb.gnt_pkt, arb.gnt_reg}), 2);

        // done_pkt and dir in the same clk: abort wins.
        arb.done_pkt = 1'b1; dir = 1'b1;
        @(negedge clk);
        arb.done_pkt = 1'b0;
        check("sim_abort", 32'(arb.abort), 1);
        check("sim_gnt_drop", 32'(arb.gnt_pkt), 0);
        @(negedge clk);
        dir = 1'b0;
        @(negedge clk);
        uclk();
        urise();
        check("after_sim_reg", 32'({arb.gnt_pkt, arb.gnt_reg}), 1);

        // Sole requester wins even though it was granted last.
        arb.done_reg = 1'b1;
        @(negedge clk);
        arb.done_reg = 1'b0;
        arb.req_pkt = 1'b0;
        uclk();
        urise();
        check("sole_reg", 32'({arb.gnt_pkt, arb.gnt_reg}), 1);
        arb.req_pkt = 1'b1;

        // Grant held without done.
`ifdef ULPI_ARB_TIMEOUT_EN
        repeat (7) uclk();
        check("to_hold7", 32'({arb.gnt_reg, arb.timeout_err}), 2);
        uclk();
        check("to_pulse", 32'(arb.timeout_err), 1);
        check("to_gnt_drop", 32'(arb.gnt_reg), 0);
        @(negedge clk);
        check("to_one_clk", 32'(arb.timeout_err), 0);
`else
        to_seen = 0;
        repeat (100) uclk();
        check("hold100_gnt", 32'(arb.gnt_reg), 1);
        check("hold100_no_to", 32'(to_seen), 0);
        arb.done_reg = 1'b1;
        @(negedge clk);
        arb.done_reg = 1'b0;
`endif
        uclk();
        urise();
        check("post_hold_pkt", 32'({arb.gnt_pkt, arb.gnt_reg}), 2);

        // Asynchronous reset mid-grant.
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_outputs", 32'({arb.gnt_pkt, arb.gnt_reg, arb.abort, arb.timeout_err}), 0);
        @(negedge clk);
        check("arst_no_abort", 32'(arb.abort), 0);
        n_rst = 1'b1;
        uclk();
        check("arst_turn_no_gnt", 32'({arb.gnt_pkt, arb.gnt_reg}), 0);
        urise();
        check("arst_pkt_first", 32'({arb.gnt_pkt, arb.gnt_reg}), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ulpi_tx_arbiter.md
# ulpi_tx_arbiter

Arbitrates the shared ULPI transmit path between the packet transmitter (payload-buffer sender) and the ULPI register-access engine. Grants ownership only while the PHY does not own the bus (dir low) and after the required turnaround. Aborts any grant the instant the PHY reclaims the bus. Sits between the requester blocks and the ULPI pin-level state machine, in the clk domain, with ulpi_clk sampled as a data input.

## Interface
- TURN_CYCLES, 1: ulpi_clk rising edges to wait after dir falls (or after reset) before any grant.
- TIMEOUT, 1024: ulpi_clk rising edges a granted requester may hold the bus without asserting done (used only with timeout feature).
- CNT_W, 11: width of the edge counter; must hold max(TURN_CYCLES, TIMEOUT).

Ports:
- clk  in  1  system clock; single clock domain.
- n_rst  in  1  asynchronous, active-low reset.
- ulpi_clk  in  1  PHY clock, sampled on clk; only its rising-edge pulse is used.
- dir  in  1  ULPI dir; high = PHY owns bus.
- nxt  in  1  ULPI nxt; monitored for busy reporting only.
- req_pkt  in  1  packet transmitter request (level).
- req_reg  in  1  register engine request (level).
- done_pkt  in  1  one-clk pulse: packet transfer finished (stp issued).
- done_reg  in  1  one-clk pulse: register transfer finished.
- gnt_pkt  out  1  packet transmitter owns the TX path.
- gnt_reg  out  1  register engine owns the TX path.
- abort  out  1  one-clk pulse: current grant revoked because dir rose.
- timeout_err  out  1  one-clk pulse: grant revoked by timeout.
- bus_busy  out  1  high whenever a grant is held or dir is high.

## Operation
- ulpi_clk_rising: one-clk pulse, registered edge detect of ulpi_clk. dir_falling likewise, from dir.
- States: IDLE, TURN, GRANT_PKT, GRANT_REG, COOLDOWN. Reset state is TURN with counter = 0.
- TURN:
  - The counter increments on each ulpi_clk_rising while dir is low.
  - If dir is high, the counter clears and the state stays TURN.
  - When the counter reaches TURN_CYCLES, go to IDLE.
- IDLE:
  - dir high → TURN, counter cleared.
  - Otherwise, on ulpi_clk_rising with any request, grant per round-robin.
  - Sole requester wins.
  - If both request, the one not in last_grant wins. last_grant resets to REG, so pkt wins the first tie.
- GRANT_x: exit only on done_x, dir high, or timeout. Deasserting req_x while granted is ignored.
  - done_x → COOLDOWN.
  - dir high → abort pulse, go to TURN.
  - last_grant is updated on grant entry.
- COOLDOWN: wait one ulpi_clk_rising, then IDLE. If dir is high, go to TURN instead.
- Simultaneous events:
  - dir high in the same clk as done_x: abort wins. Pulse abort, go to TURN.
  - done for the non-granted requester: ignored.
- gnt_pkt and gnt_reg are one-hot-or-zero, never both high.

## Timing
- All outputs are registered. Reset value of every output is 0.
- A grant goes high 1 clk after the IDLE cycle in which ulpi_clk_rising and the request coincide.
- A grant drops 1 clk after done_x, dir high, or timeout is sampled.
- abort and timeout_err go high in that same cycle, for exactly 1 clk.
- bus_busy is registered: it follows (any grant or dir) with 1 clk latency.
- Reset mid-grant: grants drop asynchronously, the state goes to TURN, and the counter clears. No abort pulse.
- Counter does not wrap; it saturates at its terminal value.

## Configuration
- ULPI_ARB_TIMEOUT_EN defined:
  - In GRANT_x, the counter counts ulpi_clk_rising edges and clears on grant entry.
  - Reaching TIMEOUT → timeout_err pulse, grant dropped, go to COOLDOWN.
- Undefined: no timeout logic. timeout_err is tied to 0. A grant is held indefinitely until done or dir.

## Structure
- Shared package usb_pkg holds:
  - the arbiter state enum (4-bit, same encoding style as the protocol state machine);
  - the requester ID enum REQ_PKT / REQ_REG;
  - defaults for TURN_CYCLES and TIMEOUT.
- One sub-module: the existing edge_detector, instantiated twice (ulpi_clk rising, dir falling).

## Test plan
- Reset, dir = 0, both requests held, TURN_CYCLES = 1 → gnt_pkt high 1 clk after the IDLE cycle where ulpi_clk_rising and the request coincide; gnt_reg stays 0.
- Both requesters active; pulse done_pkt, wait COOLDOWN → gnt_reg granted next; after done_reg → gnt_pkt again (alternation).
- gnt_reg held, dir rises → abort one clk, gnt_reg 0 next clk; no grant until dir low plus 1 ulpi_clk edge.
- done_pkt and dir rising in the same clk → abort = 1, state TURN, no COOLDOWN.
- With ULPI_ARB_TIMEOUT_EN and TIMEOUT = 8: grant held with no done for 8 ulpi_clk edges → timeout_err pulse, grant drops. Without the macro, the grant persists for 100 edges.
- n_rst asserted while gnt_pkt is high → all outputs 0 immediately, no abort; after release, TURN_CYCLES edges elapse before any grant.
